uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one UART transmitter among `N_REQ` byte producers. It accepts one byte per frame from the winning requester, launches it into the transmitter with a one-cycle start pulse, and holds the byte stable for the whole frame. The next grant is blocked until a fixed frame window expires. The transmitter samples its data input continuously and exposes no busy flag, so both the stable-hold and the frame window are required. The block sits between the producer blocks and the `tx_fsm` instance, and drives its `start` and `data_in`.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_sched_rr_arbiter.sv | 39 +++
 rtl/uart_tx_sched.sv | 110 +++++++++++
 tb/tb_uart_tx_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and constants for the UART transmit scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LAUNCH = 2'b01,
        HOLD   = 2'b10
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_sched_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick, searching from ptr+1 with wrap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IDX_W = $clog2(N);

    always_comb begin
        int  idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        // The current pointer is the last winner, so it is visited last.
        for (int off = 1; off <= N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx[IDX_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_sched.sv
// ============================================================================
// Module   : uart_tx_sched
// Brief    : Shares one UART transmitter among N_REQ producers, one byte/frame.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int FRAME_CYCLES = 128
) (
    input  logic                         clk,
    input  logic                         RST,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         tx_start,
    output logic [UART_DATA_W-1:0]       tx_data,
    output logic                         busy,
    output logic [$clog2(N_REQ)-1:0]     grant_id
);

    localparam int IDX_W   = $clog2(N_REQ);
    localparam int TIMER_W = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_LAUNCH = LAUNCH;
    localparam logic [1:0] ST_HOLD   = HOLD;

    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(FRAME_CYCLES - 1);
    localparam logic [IDX_W-1:0]   PTR_RST    = IDX_W'(N_REQ - 1);

    logic [1:0]             state;
    logic [TIMER_W-1:0]     timer;
    logic [IDX_W-1:0]       ptr;
    logic [N_REQ-1:0]       gnt;
    logic [IDX_W-1:0]       gnt_idx;
    logic [UART_DATA_W-1:0] win_data;
    logic                   in_idle;

    rr_arbiter #(
        .N(N_REQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign in_idle   = (state == ST_IDLE);
    assign req_ready = in_idle ? gnt : '0;

    // One-hot grant makes an OR-reduction mux sufficient for the winner's byte.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                win_data = win_data | req_data[i*UART_DATA_W +: UART_DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state    <= ST_IDLE;
            timer    <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            grant_id <= '0;
            ptr      <= PTR_RST;
        end else begin
            tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        tx_data  <= win_data;
                        ptr      <= gnt_idx;
                        grant_id <= gnt_idx;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    timer <= TIMER_LOAD;
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    // tx_data is deliberately left untouched when the window closes.
                    if (timer == '0) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
// ============================================================================
// Module   : tb_uart_tx_sched
// Brief    : Self-checking bench for uart_tx_sched against a frame-age model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_sched;

    localparam int N  = 4;
    localparam int FC = 128;

    logic          clk = 1'b0;
    logic          RST = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          busy;
    logic [1:0]    grant_id;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    uart_tx_sched #(
        .N_REQ        (N),
        .FRAME_CYCLES (FC)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: a frame is "active" for ages 0..FC after the accepting edge.
    bit         m_act  = 1'b0;
    int         m_age  = 0;
    int         m_last = N - 1;
    logic [7:0] m_data = 8'h00;
    int         m_grant = 0;

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int o = 1; o <= N; o++) begin
            if (v[(last + o) % N]) return (last + o) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int w;
        logic [N-1:0] er;
        w  = rr_pick(req_valid, m_last);
        er = (!m_act && w >= 0) ? N'(1 << w) : '0;
        if (chk_en) begin
            check("req_ready", req_ready, er);
            check("tx_start",  tx_start,  (m_act && m_age == 0));
            check("busy",      busy,      m_act);
            check("tx_data",   tx_data,   m_data);
            check("grant_id",  grant_id,  m_grant);
        end
        if (RST) begin
            m_act = 1'b0; m_age = 0; m_last = N - 1; m_data = 8'h00; m_grant = 0;
        end else if (!m_act && w >= 0) begin
            m_act = 1'b1; m_age = 0; m_last = w; m_grant = w;
            m_data = req_data[w*8 +: 8];
        end else if (m_act) begin
            m_age++;
            if (m_age > FC) m_act = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 400; t++) begin
            if (!busy) return;
            tick();
        end
        checks++; errors++;
        $display("FAIL idle_timeout: busy still 1 after 400 cycles, required 0");
    endtask

    // Waits for a handshake; optionally drops the accepted valid afterwards.
    task automatic wait_grant(input bit drop, output int id, output int at);
        logic [N-1:0] hs;
        id = -1;
        at = -1;
        for (int t = 0; t < 400; t++) begin
            #1;
            hs = req_valid & req_ready;
            if (hs != '0) begin
                for (int i = 0; i < N; i++) if (hs[i]) id = i;
                at = cyc;
                tick();
                if (drop) req_valid[id] = 1'b0;
                return;
            end
            tick();
        end
        checks++; errors++;
        $display("FAIL grant_timeout: no handshake in 400 cycles, required one");
    endtask

    initial begin
        int id, at, prev, nb;
        logic [N-1:0] hs;

        // Reset state and single requester
        do_reset();
        chk_en = 1'b1;
        check("rst_busy", busy, 1'b0);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_grant_id", grant_id, 2'd0);
        req_data[7:0] = 8'hA5;
        req_valid     = 4'b0001;
        #1;
        check("t1_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        check("t1_start", tx_start, 1'b1);
        check("t1_data", tx_data, 8'hA5);
        nb = 1;
        for (int t = 0; t < 300; t++) begin
            tick();
            if (!busy) break;
            nb++;
        end
        check("t1_busy_len", nb, 129);
        check("t1_start_gone", tx_start, 1'b0);
        check("t1_data_held", tx_data, 8'hA5);

        // All four continuously valid
        do_reset();
        req_data  = {8'h43, 8'h32, 8'h21, 8'h10};
        req_valid = 4'b1111;
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            wait_grant(1'b0, id, at);
            check("t2_order", id, g % N);
            if (g > 0) check("t2_period", at - prev, FC + 2);
            prev = at;
        end
        check("t2_grant_id", grant_id, 2'd0);
        check("t2_data", tx_data, 8'h10);
        req_valid = '0;
        wait_idle();

        // Rotation from ptr+1 with wrap
        do_reset();
        req_valid = 4'b0100;
        wait_grant(1'b1, id, at);
        check("t3_first", id, 2);
        req_valid = req_valid | 4'b1010;
        wait_grant(1'b1, id, at);
        check("t3_second", id, 3);
        wait_grant(1'b1, id, at);
        check("t3_third", id, 1);
        wait_idle();

        // Valid raised during HOLD waits for the window
        req_valid = 4'b0001;
        wait_grant(1'b1, id, prev);
        for (int t = 0; t < 20; t++) tick();
        req_valid[1] = 1'b1;
        #1;
        check("t4_ready_hold", req_ready, 4'b0000);
        wait_grant(1'b1, id, at);
        check("t4_id", id, 1);
        check("t4_gap", at - prev, FC + 2);
        wait_idle();

        // Data held across mid-frame input change
        req_data[7:0] = 8'h5A;
        req_valid     = 4'b0001;
        wait_grant(1'b1, id, at);
        for (int t = 0; t < 50; t++) tick();
        req_data[7:0] = 8'hFF;
        for (int t = 0; t < 70; t++) tick();
        check("t5_busy", busy, 1'b1);
        check("t5_data", tx_data, 8'h5A);

        // Reset in HOLD
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("t6_busy", busy, 1'b0);
        check("t6_data", tx_data, 8'h00);
        check("t6_start", tx_start, 1'b0);
        req_valid = 4'b1111;
        wait_grant(1'b1, id, at);
        check("t6_first", id, 0);
        req_valid = '0;
        wait_idle();

        // Randomized traffic with withdrawals and occasional resets
        hs = '0;
        for (int c = 0; c < 9000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 39) == 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[i*8 +: 8] = 8'($urandom);
                end else if (req_valid[i] && $urandom_range(0, 299) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            RST = ($urandom_range(0, 2999) == 0);
            #1;
            hs = RST ? '0 : (req_valid & req_ready);
            tick();
        end
        RST       = 1'b0;
        req_valid = '0;
        tick();
        wait_idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
